// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32 subset datapath: steps one instruction through
// FETCH/DECODE/EXEC/MEM/WB with watchdog-guarded memory handshakes and a retire counter.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       Op_i,
  input  logic             Zero_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCSrc_o,
  output logic             RegWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state_r;
  logic [6:0]       op_r;
  logic [7:0]       timer_r;
  logic [CNT_W-1:0] instret_r;
  logic             trap_r;
  logic [1:0]       cause_r;
  logic             retire_s;
  logic             tmo_s;
  state_t           ret_state_s;

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LD, OP_ST, OP_BR: legal_op = 1'b1;
      default:                         legal_op = 1'b0;
    endcase
  endfunction

  assign tmo_s = (timer_r == TMO_LAST);

  // Retire detection and the instruction-boundary destination shared by all retire points
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_EXEC:  retire_s = (op_r == OP_BR);
      S_MEM:   retire_s = dmem_ack_i && (op_r == OP_ST);
      S_WB:    retire_s = 1'b1;
      default: retire_s = 1'b0;
    endcase
    if (start_i) begin
      ret_state_s = S_FETCH;
    end else begin
      ret_state_s = S_IDLE;
    end
  end

  // State, latched opcode, watchdog timer, retire counter and sticky trap record
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= S_IDLE;
      op_r      <= 7'd0;
      timer_r   <= 8'd0;
      instret_r <= '0;
      trap_r    <= 1'b0;
      cause_r   <= 2'b00;
    end else begin
      if (retire_s) begin
        instret_r <= instret_r + CNT_W'(1);
      end
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            state_r <= S_FETCH;
            timer_r <= 8'd0;
          end
        end
        S_FETCH: begin
          // An ack on the final watchdog cycle still wins over the timeout
          if (imem_ack_i) begin
            state_r <= S_DECODE;
            timer_r <= 8'd0;
          end else if (tmo_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b10;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        S_DECODE: begin
          op_r <= Op_i;
          if (legal_op(Op_i)) begin
            state_r <= S_EXEC;
          end else begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b01;
          end
        end
        S_EXEC: begin
          case (op_r)
            OP_R, OP_I: state_r <= S_WB;
            OP_LD, OP_ST: begin
              state_r <= S_MEM;
              timer_r <= 8'd0;
            end
            OP_BR: begin
              state_r <= ret_state_s;
              timer_r <= 8'd0;
            end
            default: begin
              state_r <= S_TRAP;
              trap_r  <= 1'b1;
              cause_r <= 2'b01;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack_i) begin
            timer_r <= 8'd0;
            if (op_r == OP_LD) begin
              state_r <= S_WB;
            end else begin
              state_r <= ret_state_s;
            end
          end else if (tmo_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b11;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        S_WB: begin
          state_r <= ret_state_s;
          timer_r <= 8'd0;
        end
        S_TRAP:  state_r <= S_TRAP;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Datapath enables decoded from state, latched opcode, acks and the zero flag
  always_comb begin
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 1'b0;
    RegWrite_o = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    ALUSrc_o   = 1'b0;
    ALUOp_o    = 2'b00;
    case (state_r)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
        end else begin
          IRWrite_o = 1'b0;
          PCWrite_o = 1'b0;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_R: ALUOp_o = 2'b10;
          OP_I: begin
            ALUOp_o  = 2'b11;
            ALUSrc_o = 1'b1;
          end
          OP_LD, OP_ST: ALUSrc_o = 1'b1;
          OP_BR: begin
            ALUOp_o = 2'b01;
            if (Zero_i) begin
              PCWrite_o = 1'b1;
              PCSrc_o   = 1'b1;
            end else begin
              PCWrite_o = 1'b0;
              PCSrc_o   = 1'b0;
            end
          end
          default: ALUOp_o = 2'b00;
        endcase
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        MemRead_o  = (op_r == OP_LD);
        MemWrite_o = (op_r == OP_ST);
      end
      S_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = (op_r == OP_LD);
      end
      default: imem_req_o = 1'b0;
    endcase
  end

  assign state_o      = state_r;
  assign busy_o       = (state_r != S_IDLE) && (state_r != S_TRAP);
  assign trap_o       = trap_r;
  assign trap_cause_o = cause_r;
  assign instret_o    = instret_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Vector/scoreboard bench for multicycle_control: per-cycle expected control words are
// queued as stimulus is applied and compared on the falling edge.
module tb_multicycle_control;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  // {imem_req, dmem_req, IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[1:0]}
  localparam logic [11:0] C_NONE   = 12'b0000_0000_0000;
  localparam logic [11:0] C_F_REQ  = 12'b1000_0000_0000;
  localparam logic [11:0] C_F_ACK  = 12'b1011_0000_0000;
  localparam logic [11:0] C_EX_R   = 12'b0000_0000_0010;
  localparam logic [11:0] C_EX_I   = 12'b0000_0000_0111;
  localparam logic [11:0] C_EX_LS  = 12'b0000_0000_0100;
  localparam logic [11:0] C_EX_BRZ = 12'b0001_1000_0001;
  localparam logic [11:0] C_EX_BRN = 12'b0000_0000_0001;
  localparam logic [11:0] C_MEM_LD = 12'b0100_0010_0000;
  localparam logic [11:0] C_MEM_ST = 12'b0100_0001_0000;
  localparam logic [11:0] C_WB_RI  = 12'b0000_0100_0000;
  localparam logic [11:0] C_WB_LD  = 12'b0000_0100_1000;

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic [6:0]  op;
    logic        zero;
    logic        iack;
    logic        dack;
    logic [2:0]  st;
    logic [11:0] ctl;
    logic        busy;
    logic        trap;
    logic [1:0]  cause;
    logic [3:0]  instret;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       iack = 1'b0;
  logic       dack = 1'b0;
  logic       imem_req, dmem_req, irwrite, pcwrite, pcsrc, regwrite;
  logic       memread, memwrite, memtoreg, alusrc;
  logic [1:0] aluop;
  logic [2:0] state;
  logic       busy, trap;
  logic [1:0] cause;
  logic [3:0] instret;

  vec_t        exp_q[$];
  vec_t        tbl[$];
  vec_t        e_v;
  logic [11:0] act_ctl;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .Zero_i(zero),
    .imem_ack_i(iack), .dmem_ack_i(dack),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .IRWrite_o(irwrite), .PCWrite_o(pcwrite),
    .PCSrc_o(pcsrc), .RegWrite_o(regwrite), .MemRead_o(memread), .MemWrite_o(memwrite),
    .MemtoReg_o(memtoreg), .ALUSrc_o(alusrc), .ALUOp_o(aluop), .state_o(state),
    .busy_o(busy), .trap_o(trap), .trap_cause_o(cause), .instret_o(instret)
  );

  function automatic vec_t mk(string name, logic r, logic s, logic [6:0] o, logic z, logic ia,
                              logic da, logic [2:0] st, logic [11:0] ctl, logic tr,
                              logic [1:0] ca, logic [3:0] ir);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.op = o; v.zero = z; v.iack = ia; v.dack = da;
    v.st = st; v.ctl = ctl; v.busy = (st != S_IDLE) && (st != S_TRAP);
    v.trap = tr; v.cause = ca; v.instret = ir;
    return v;
  endfunction

  function automatic vec_t v_idle(string n, logic s, logic [3:0] ir);
    return mk(n, 1'b1, s, 7'd0, 1'b0, 1'b0, 1'b0, S_IDLE, C_NONE, 1'b0, 2'b00, ir);
  endfunction
  function automatic vec_t v_fetch(string n, logic ia, logic [3:0] ir);
    return mk(n, 1'b1, 1'b1, 7'd0, 1'b0, ia, 1'b0, S_FETCH, ia ? C_F_ACK : C_F_REQ, 1'b0, 2'b00, ir);
  endfunction
  // Stray acks during DECODE must be ignored
  function automatic vec_t v_dec(string n, logic [6:0] o, logic [3:0] ir);
    return mk(n, 1'b1, 1'b1, o, 1'b0, 1'b1, 1'b1, S_DECODE, C_NONE, 1'b0, 2'b00, ir);
  endfunction
  function automatic vec_t v_exec(string n, logic [11:0] c, logic z, logic s, logic [3:0] ir);
    return mk(n, 1'b1, s, 7'd0, z, 1'b0, 1'b0, S_EXEC, c, 1'b0, 2'b00, ir);
  endfunction
  function automatic vec_t v_mem(string n, logic [11:0] c, logic da, logic s, logic [3:0] ir);
    return mk(n, 1'b1, s, 7'd0, 1'b0, 1'b0, da, S_MEM, c, 1'b0, 2'b00, ir);
  endfunction
  function automatic vec_t v_wb(string n, logic [11:0] c, logic s, logic [3:0] ir);
    return mk(n, 1'b1, s, 7'd0, 1'b0, 1'b0, 1'b0, S_WB, c, 1'b0, 2'b00, ir);
  endfunction
  function automatic vec_t v_trap(string n, logic [1:0] ca, logic [3:0] ir);
    return mk(n, 1'b1, 1'b1, 7'd0, 1'b1, 1'b1, 1'b1, S_TRAP, C_NONE, 1'b1, ca, ir);
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; start = v.start; op = v.op; zero = v.zero; iack = v.iack; dack = v.dack;
    exp_q.push_back(v);
  endtask

  // Scoreboard: compare the oldest queued expectation against the settled outputs
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      act_ctl = {imem_req, dmem_req, irwrite, pcwrite, pcsrc, regwrite,
                 memread, memwrite, memtoreg, alusrc, aluop};
      n_cmp++;
      if ({state, act_ctl, busy, trap, cause, instret} !==
          {e_v.st, e_v.ctl, e_v.busy, e_v.trap, e_v.cause, e_v.instret}) begin
        n_bad++;
        $display("FAIL %s: got st=%0d ctl=%b busy=%b trap=%b cause=%b instret=%0d, want st=%0d ctl=%b busy=%b trap=%b cause=%b instret=%0d",
                 e_v.name, state, act_ctl, busy, trap, cause, instret,
                 e_v.st, e_v.ctl, e_v.busy, e_v.trap, e_v.cause, e_v.instret);
      end
    end
  end

  initial begin
    tbl.push_back(v_idle("rst_idle", 1'b0, 4'd0));
    tbl.push_back(v_idle("r_idle", 1'b1, 4'd0));
    tbl.push_back(v_fetch("r_fetch", 1'b1, 4'd0));
    tbl.push_back(v_dec("r_dec", OP_R, 4'd0));
    tbl.push_back(v_exec("r_exec", C_EX_R, 1'b0, 1'b1, 4'd0));
    tbl.push_back(v_wb("r_wb", C_WB_RI, 1'b1, 4'd0));
    tbl.push_back(v_fetch("i_fetch", 1'b1, 4'd1));
    tbl.push_back(v_dec("i_dec", OP_I, 4'd1));
    tbl.push_back(v_exec("i_exec", C_EX_I, 1'b0, 1'b1, 4'd1));
    tbl.push_back(v_wb("i_wb", C_WB_RI, 1'b1, 4'd1));
    tbl.push_back(v_fetch("ld_fetch", 1'b1, 4'd2));
    tbl.push_back(v_dec("ld_dec", OP_LD, 4'd2));
    tbl.push_back(v_exec("ld_exec", C_EX_LS, 1'b0, 1'b1, 4'd2));
    tbl.push_back(v_mem("ld_mem0", C_MEM_LD, 1'b0, 1'b1, 4'd2));
    tbl.push_back(v_mem("ld_mem1", C_MEM_LD, 1'b0, 1'b1, 4'd2));
    tbl.push_back(v_mem("ld_mem2", C_MEM_LD, 1'b1, 1'b1, 4'd2));
    tbl.push_back(v_wb("ld_wb", C_WB_LD, 1'b1, 4'd2));
    tbl.push_back(v_fetch("brz_fetch", 1'b1, 4'd3));
    tbl.push_back(v_dec("brz_dec", OP_BR, 4'd3));
    tbl.push_back(v_exec("brz_exec", C_EX_BRZ, 1'b1, 1'b1, 4'd3));
    tbl.push_back(v_fetch("brn_fetch", 1'b1, 4'd4));
    tbl.push_back(v_dec("brn_dec", OP_BR, 4'd4));
    tbl.push_back(v_exec("brn_exec", C_EX_BRN, 1'b0, 1'b0, 4'd4));
    tbl.push_back(v_idle("brn_idle", 1'b0, 4'd5));
    tbl.push_back(v_idle("st_idle", 1'b1, 4'd5));
    tbl.push_back(v_fetch("st_fwait", 1'b0, 4'd5));
    tbl.push_back(v_fetch("st_fetch", 1'b1, 4'd5));
    tbl.push_back(v_dec("st_dec", OP_ST, 4'd5));
    tbl.push_back(v_exec("st_exec", C_EX_LS, 1'b0, 1'b1, 4'd5));
    tbl.push_back(v_mem("st_mem", C_MEM_ST, 1'b1, 1'b1, 4'd5));

    rst = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

    // Reset asserted in the middle of a load's MEM phase
    apply(v_fetch("rm_fetch", 1'b1, 4'd6));
    apply(v_dec("rm_dec", OP_LD, 4'd6));
    apply(v_exec("rm_exec", C_EX_LS, 1'b0, 1'b1, 4'd6));
    apply(v_mem("rm_mem", C_MEM_LD, 1'b0, 1'b1, 4'd6));
    apply(mk("rm_rst", 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, S_MEM, C_MEM_LD, 1'b0, 2'b00, 4'd6));
    apply(v_idle("rm_idle", 1'b0, 4'd0));

    // Sixteen retires wrap the 4-bit counter back to zero
    apply(v_idle("wr_idle", 1'b1, 4'd0));
    for (int i = 0; i < 16; i++) begin
      apply(v_fetch("wr_fetch", 1'b1, 4'(i)));
      apply(v_dec("wr_dec", OP_BR, 4'(i)));
      apply(v_exec("wr_exec", C_EX_BRN, 1'b0, (i != 15), 4'(i)));
    end
    apply(v_idle("wr_wrapped", 1'b0, 4'd0));

    // imem ack on the last watchdog cycle wins
    apply(v_idle("fb_idle", 1'b1, 4'd0));
    repeat (15) apply(v_fetch("fb_wait", 1'b0, 4'd0));
    apply(v_fetch("fb_ack_last", 1'b1, 4'd0));
    apply(v_dec("fb_dec", OP_R, 4'd0));
    apply(v_exec("fb_exec", C_EX_R, 1'b0, 1'b1, 4'd0));
    apply(v_wb("fb_wb", C_WB_RI, 1'b0, 4'd0));
    apply(v_idle("fb_idle2", 1'b0, 4'd1));

    // Illegal opcode traps without retiring
    apply(v_idle("il_idle", 1'b1, 4'd1));
    apply(v_fetch("il_fetch", 1'b1, 4'd1));
    apply(v_dec("il_dec", OP_BAD, 4'd1));
    repeat (2) apply(v_trap("il_trap", 2'b01, 4'd1));
    apply(mk("il_rst", 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, S_TRAP, C_NONE, 1'b1, 2'b01, 4'd1));
    apply(v_idle("il_clr", 1'b0, 4'd0));

    // Store whose dmem ack never arrives
    apply(v_idle("sto_idle", 1'b1, 4'd0));
    apply(v_fetch("sto_fetch", 1'b1, 4'd0));
    apply(v_dec("sto_dec", OP_ST, 4'd0));
    apply(v_exec("sto_exec", C_EX_LS, 1'b0, 1'b1, 4'd0));
    repeat (16) apply(v_mem("sto_mem", C_MEM_ST, 1'b0, 1'b1, 4'd0));
    repeat (3) apply(v_trap("sto_trap", 2'b11, 4'd0));
    apply(mk("sto_rst", 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, S_TRAP, C_NONE, 1'b1, 2'b11, 4'd0));
    apply(v_idle("sto_clr", 1'b0, 4'd0));

    // Instruction fetch whose ack never arrives
    apply(v_idle("ito_idle", 1'b1, 4'd0));
    repeat (16) apply(v_fetch("ito_wait", 1'b0, 4'd0));
    repeat (2) apply(v_trap("ito_trap", 2'b10, 4'd0));

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
